hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the 5-stage MIPS32 core.
- Sits beside the forwarding unit and drives pipeline-register write enables, bubble insertion and flushes.
- Handles three cases:
  - load-use hazards, which forwarding cannot cover;
  - taken-branch flushes;
  - multi-cycle data-memory waits, with a watchdog timeout.

---
 rtl/hazard_ctrl_pkg.sv | 22 ++
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl_load_use_det.sv | 17 +
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_hazard_ctrl.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: state encoding, register
// address width and the control-output bundle.
package hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT_ERR = 2'd2
    } hc_state_e;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_freeze;
    } pipe_ctrl_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signals seen by the hazard controller. The slave modport is
// the controller; the master modport is whoever drives the pipeline inputs.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] ex_rt;
    logic                  ex_mem_read;
    logic                  branch_taken;
    logic                  mem_req;
    logic                  mem_ready;

    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
    logic mem_timeout;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read,
               branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_mem_read,
               branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_bubble,
               pipe_freeze, mem_timeout
    );

endinterface

// File: rtl/hazard_ctrl_load_use_det.sv
// Combinational load-use detector: a load in EX whose destination is read by
// the instruction in ID. Register zero never creates a dependency.
module load_use_det
    import hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic                  id_uses_rt,
    input  logic [REG_ADDR_W-1:0] ex_rt,
    input  logic                  ex_mem_read,
    output logic                  load_use
);

    assign load_use = ex_mem_read && (ex_rt != REG_ZERO) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch flushes and
// data-memory wait freezes with a watchdog. Optional HAZARD_CTRL_STATS_EN adds counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
`ifdef HAZARD_CTRL_STATS_EN
    ,
    output logic [31:0]   stall_cnt,
    output logic [31:0]   flush_cnt,
    output logic [31:0]   wait_cnt_total
`endif
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
    localparam pipe_ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, default: 1'b0};
    localparam pipe_ctrl_t CTRL_FREEZE = '{pipe_freeze: 1'b1, default: 1'b0};
    localparam pipe_ctrl_t CTRL_RESET  = '{if_id_flush: 1'b1, id_ex_bubble: 1'b1, default: 1'b0};

    hc_state_e         state, state_nx;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic              mem_timeout, mem_timeout_nx;
    logic              load_use;
    logic              mem_stall;
    pipe_ctrl_t        ctrl;

    load_use_det u_load_use_det (
        .id_rs       (hz.id_rs),
        .id_rt       (hz.id_rt),
        .id_uses_rt  (hz.id_uses_rt),
        .ex_rt       (hz.ex_rt),
        .ex_mem_read (hz.ex_mem_read),
        .load_use    (load_use)
    );

    assign mem_stall = hz.mem_req && !hz.mem_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            wait_cnt    <= wait_cnt_nx;
            mem_timeout <= mem_timeout_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        wait_cnt_nx    = wait_cnt;
        mem_timeout_nx = mem_timeout;
        ctrl           = CTRL_RUN;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    ctrl        = CTRL_FREEZE;
                    wait_cnt_nx = WAIT_W'(1);
                    state_nx    = MEM_WAIT;
                end else if (branch_now()) begin
                    // ID instruction is discarded, so a coincident load-use is moot
                    ctrl = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                             id_ex_bubble: 1'b1, pipe_freeze: 1'b0};
                end else if (load_use) begin
                    ctrl = '{id_ex_bubble: 1'b1, default: 1'b0};
                end
            end
            MEM_WAIT: begin
                ctrl = CTRL_FREEZE;
                if (hz.mem_ready) begin
                    state_nx    = RUN;
                    wait_cnt_nx = '0;
                end else if (wait_cnt == MAX_WAIT_C) begin
                    mem_timeout_nx = 1'b1;
                    state_nx       = HALT_ERR;
                end else if (wait_cnt != '1) begin
                    wait_cnt_nx = wait_cnt + WAIT_W'(1);
                end
            end
            HALT_ERR: begin
                ctrl = CTRL_FREEZE;
            end
            default: begin
                ctrl     = CTRL_FREEZE;
                state_nx = RUN;
            end
        endcase
        if (rst) ctrl = CTRL_RESET;
    end

    function automatic logic branch_now();
        return hz.branch_taken;
    endfunction

    assign hz.pc_write     = ctrl.pc_write;
    assign hz.if_id_write  = ctrl.if_id_write;
    assign hz.if_id_flush  = ctrl.if_id_flush;
    assign hz.id_ex_bubble = ctrl.id_ex_bubble;
    assign hz.pipe_freeze  = ctrl.pipe_freeze;
    assign hz.mem_timeout  = mem_timeout;

`ifdef HAZARD_CTRL_STATS_EN
    logic stall_ev, flush_ev, wait_ev;

    assign flush_ev = (state == RUN) && !mem_stall && hz.branch_taken;
    assign stall_ev = (state == RUN) && !mem_stall && !hz.branch_taken && load_use;
    assign wait_ev  = (state == MEM_WAIT);

    // Event counters saturate rather than wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt      <= '0;
            flush_cnt      <= '0;
            wait_cnt_total <= '0;
        end else begin
            if (stall_ev && stall_cnt != '1)      stall_cnt      <= stall_cnt + 32'd1;
            if (flush_ev && flush_cnt != '1)      flush_cnt      <= flush_cnt + 32'd1;
            if (wait_ev && wait_cnt_total != '1)  wait_cnt_total <= wait_cnt_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (MAX_WAIT=4): stimulus pushes expected
// control outputs, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    // {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_timeout}
    localparam logic [5:0] E_RST   = 6'b001100;
    localparam logic [5:0] E_NORM  = 6'b110000;
    localparam logic [5:0] E_STALL = 6'b000100;
    localparam logic [5:0] E_FLUSH = 6'b111100;
    localparam logic [5:0] E_FRZ   = 6'b000010;
    localparam logic [5:0] E_HALT  = 6'b000011;

    typedef struct {
        string      name;
        logic [5:0] v;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    logic probe = 1'b0;
    int   nchk = 0;
    int   nerr = 0;
    exp_t q[$];

    hazard_ctrl_if hz();

`ifdef HAZARD_CTRL_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, wait_cnt_total;
`endif

    hazard_ctrl #(.MAX_WAIT(4), .WAIT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz.slave)
`ifdef HAZARD_CTRL_STATS_EN
        ,
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .wait_cnt_total (wait_cnt_total)
`endif
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // One cycle of stimulus applied just after the rising edge
    task automatic step(input logic r, input string nm,
                        input logic [4:0] rs, input logic [4:0] rt, input logic uses,
                        input logic [4:0] ert, input logic mrd, input logic br,
                        input logic mreq, input logic mrdy, input logic [5:0] e);
        exp_t x;
        @(posedge clk);
        #1;
        rst              = r;
        hz.id_rs         = rs;
        hz.id_rt         = rt;
        hz.id_uses_rt    = uses;
        hz.ex_rt         = ert;
        hz.ex_mem_read   = mrd;
        hz.branch_taken  = br;
        hz.mem_req       = mreq;
        hz.mem_ready     = mrdy;
        x.name = nm;
        x.v    = e;
        q.push_back(x);
    endtask

    initial begin : monitor
        exp_t       e;
        logic [5:0] got;
        forever begin
            @(negedge clk or posedge probe);
            while (q.size() > 0) begin
                e   = q.pop_front();
                got = {hz.pc_write, hz.if_id_write, hz.if_id_flush,
                       hz.id_ex_bubble, hz.pipe_freeze, hz.mem_timeout};
                chk(e.name, {26'd0, got}, {26'd0, e.v});
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin : stim
        hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0; hz.ex_rt = '0;
        hz.ex_mem_read = 1'b0; hz.branch_taken = 1'b0;
        hz.mem_req = 1'b0; hz.mem_ready = 1'b0;

        //   rst name           rs rt u ert mr br mq rdy expected
        step(1, "reset_lu",     8, 0, 0, 8, 1, 0, 0, 0, E_RST);
        step(1, "reset_mem",    0, 0, 0, 0, 0, 0, 1, 0, E_RST);
        step(0, "idle",         0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
        step(0, "lu_rs",        8, 0, 0, 8, 1, 0, 0, 0, E_STALL);
        step(0, "lu_after",     8, 0, 0, 8, 0, 0, 0, 0, E_NORM);
        step(0, "zero_reg",     0, 0, 0, 0, 1, 0, 0, 0, E_NORM);
        step(0, "rt_unused",    0, 9, 0, 9, 1, 0, 0, 0, E_NORM);
        step(0, "lu_rt",        0, 9, 1, 9, 1, 0, 0, 0, E_STALL);
        step(0, "br_beats_lu",  8, 0, 0, 8, 1, 1, 0, 0, E_FLUSH);
        step(0, "mem_rdy_now",  8, 0, 0, 8, 1, 0, 1, 1, E_STALL);
        step(0, "mw_enter",     0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "mw_br_ign",    0, 0, 0, 0, 0, 1, 1, 0, E_FRZ);
        step(0, "mw_lu_ign",    8, 0, 0, 8, 1, 0, 1, 0, E_FRZ);
        step(0, "mw_done",      0, 0, 0, 0, 0, 0, 1, 1, E_FRZ);
        step(0, "mw_exit",      0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
        step(0, "mw_exit_br",   0, 0, 0, 0, 0, 1, 0, 0, E_FLUSH);

        // Reset mid-wait, then a counted sequence for the statistics
        step(0, "mw2_enter",    0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(1, "rst_mid_wait", 0, 0, 0, 0, 0, 0, 1, 0, E_RST);
        step(0, "post_rst",     0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
        step(0, "st_lu1",       3, 0, 0, 3, 1, 0, 0, 0, E_STALL);
        step(0, "st_idle",      0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
        step(0, "st_lu2",       0, 4, 1, 4, 1, 0, 0, 0, E_STALL);
        step(0, "st_br",        0, 0, 0, 0, 0, 1, 0, 0, E_FLUSH);
        step(0, "st_mw0",       0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "st_mw1",       0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "st_mw2",       0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "st_mw_done",   0, 0, 0, 0, 0, 0, 1, 1, E_FRZ);
        step(0, "st_idle2",     0, 0, 0, 0, 0, 0, 0, 0, E_NORM);
`ifdef HAZARD_CTRL_STATS_EN
        @(negedge clk);
        chk("stall_cnt",      stall_cnt,      32'd2);
        chk("flush_cnt",      flush_cnt,      32'd1);
        chk("wait_cnt_total", wait_cnt_total, 32'd3);
`endif

        // Watchdog: five frozen cycles, then sticky timeout in HALT_ERR
        step(1, "rst_to",       0, 0, 0, 0, 0, 0, 0, 0, E_RST);
        step(0, "to_c0",        0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "to_c1",        0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "to_c2",        0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "to_c3",        0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "to_c4",        0, 0, 0, 0, 0, 0, 1, 0, E_FRZ);
        step(0, "to_halt",      0, 0, 0, 0, 0, 0, 1, 0, E_HALT);
        step(0, "to_halt_rdy",  0, 0, 0, 0, 0, 1, 1, 1, E_HALT);
        step(0, "to_halt_idle", 8, 0, 0, 8, 1, 0, 0, 0, E_HALT);

        // Stop the clock and show reset clears the flag without an edge
        @(negedge clk);
        clk_en = 1'b0;
        #2;
        rst = 1'b1;
        begin
            exp_t x;
            x.name = "async_rst";
            x.v    = E_RST;
            q.push_back(x);
        end
        #1 probe = 1'b1;
        #2;
        chk("queue_drained", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
